// File: rtl/pc_gen.sv
// Fetch-stage PC generator: trap/redirect/stall/RAS/sequential next-PC select
// with misaligned-redirect detection and a circular return-address stack.
module pc_gen #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic            pd_call,
  input  logic            pd_ret,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            fetch_valid,
  output logic            pred_taken_f,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_INIT, SEL_TRAP, SEL_MISALIGN, SEL_REDIR, SEL_STALL, SEL_RAS, SEL_SEQ
  } sel_e;

  typedef struct packed {
    logic            we;
    logic [PTR_W-1:0] addr;
    logic [XLEN-1:0] data;
  } ras_wr_t;

  logic [XLEN-1:0]                 pc_q, pc_d;
  logic                            fv_q, fv_d;
  logic                            pt_q, pt_d;
  logic                            mis_q, mis_d;
  logic [XLEN-1:0]                 bad_q, bad_d;
  logic [RAS_DEPTH-1:0][XLEN-1:0]  ras_q;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  sel_e            sel;
  ras_wr_t         ras_wr;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            do_pop;
  logic            do_push;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign ras_empty = (cnt_q == '0);
  // ptr_q always names the next free slot, so the top sits one below it.
  assign ras_top   = ras_q[ptr_q - PTR_ONE];

  always_comb begin
    sel = SEL_SEQ;
    if (!fv_q)                                   sel = SEL_INIT;
    else if (trap_valid)                         sel = SEL_TRAP;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) sel = SEL_MISALIGN;
    else if (redirect_valid)                     sel = SEL_REDIR;
    else if (stall_f)                            sel = SEL_STALL;
    else if (pd_ret && !ras_empty)               sel = SEL_RAS;
  end

  always_comb begin
    pc_d    = pc_q;
    fv_d    = 1'b1;
    pt_d    = pt_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ras_wr  = '{we: 1'b0, addr: ptr_q, data: pc_plus4};
    do_pop  = 1'b0;
    do_push = 1'b0;

    unique case (sel)
      SEL_INIT: ;
      SEL_TRAP: begin
        pc_d = TRAP_VECTOR;
        pt_d = 1'b0;
      end
      SEL_MISALIGN: begin
        pc_d  = TRAP_VECTOR;
        pt_d  = 1'b0;
        mis_d = 1'b1;
        bad_d = redirect_pc;
      end
      SEL_REDIR: begin
        pc_d = redirect_pc;
        pt_d = 1'b0;
      end
      SEL_STALL: ;
      SEL_RAS: begin
        pc_d    = ras_top;
        pt_d    = 1'b1;
        do_pop  = 1'b1;
        do_push = pd_call;
      end
      default: begin
        pc_d    = pc_plus4;
        pt_d    = 1'b0;
        do_push = pd_call;
      end
    endcase

    // Pop+push collapses into an in-place overwrite of the top slot.
    if (do_pop && do_push) begin
      ras_wr.we   = 1'b1;
      ras_wr.addr = ptr_q - PTR_ONE;
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end else if (do_push) begin
      ras_wr.we = 1'b1;
      ptr_d     = ptr_q + PTR_ONE;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      fv_q  <= 1'b0;
      pt_q  <= 1'b0;
      mis_q <= 1'b0;
      bad_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ras_q <= '0;
    end else begin
      pc_q  <= pc_d;
      fv_q  <= fv_d;
      pt_q  <= pt_d;
      mis_q <= mis_d;
      bad_q <= bad_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (ras_wr.we) ras_q[ras_wr.addr] <= ras_wr.data;
    end
  end

  assign pc_f         = pc_q;
  assign pc_plus4_f   = pc_plus4;
  assign fetch_valid  = fv_q;
  assign pred_taken_f = pt_q;
  assign misalign_o   = mis_q;
  assign bad_addr_o   = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboarded random + directed bench for pc_gen against a queue-based RAS model.
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RSTV  = 32'h0000_0000;
  localparam logic [31:0] TRAPV = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
  logic        pd_call = 1'b0, pd_ret = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_f, pc_plus4_f, bad_addr_o;
  logic        fetch_valid, pred_taken_f, misalign_o;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RSTV), .TRAP_VECTOR(TRAPV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .pd_call(pd_call), .pd_ret(pd_ret),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .fetch_valid(fetch_valid),
    .pred_taken_f(pred_taken_f), .misalign_o(misalign_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        pt;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_fv, m_pt, m_mis;
  logic [31:0] m_bad;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RSTV; m_fv = 1'b0; m_pt = 1'b0; m_mis = 1'b0; m_bad = '0;
    m_ras.delete();
  endtask

  // Called just after a falling edge: drive inputs, predict the next edge, wait one cycle.
  task automatic step(input logic trap, input logic redir, input logic [31:0] rpc,
                      input logic stall, input logic call, input logic ret);
    logic [31:0] p4;
    exp_t e;
    trap_valid = trap; redirect_valid = redir; redirect_pc = rpc;
    stall_f = stall; pd_call = call; pd_ret = ret;
    m_mis = 1'b0;
    if (!m_fv) begin
      m_fv = 1'b1;
    end else if (trap) begin
      m_pc = TRAPV; m_pt = 1'b0;
    end else if (redir && rpc[1:0] != 2'b00) begin
      m_pc = TRAPV; m_pt = 1'b0; m_mis = 1'b1; m_bad = rpc;
    end else if (redir) begin
      m_pc = rpc; m_pt = 1'b0;
    end else if (!stall) begin
      p4 = m_pc + 32'd4;
      if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_pt = 1'b1;
      end else begin
        m_pc = p4; m_pt = 1'b0;
      end
      if (call) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    e.pc = m_pc; e.fv = m_fv; e.pt = m_pt; e.mis = m_mis; e.bad = m_bad;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic go(input logic [31:0] a);
    step(0, 1, a, 0, 0, 0);
  endtask

  // Monitor: compare every edge that has a pending prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_f",         pc_f,                 e.pc);
        chk("pc_plus4_f",   pc_plus4_f,           e.pc + 32'd4);
        chk("fetch_valid",  {31'b0, fetch_valid}, {31'b0, e.fv});
        chk("pred_taken_f", {31'b0, pred_taken_f},{31'b0, e.pt});
        chk("misalign_o",   {31'b0, misalign_o},  {31'b0, e.mis});
        chk("bad_addr_o",   bad_addr_o,           e.bad);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},  pc_f,                  RSTV);
    chk({tag, "_fv"},  {31'b0, fetch_valid},  32'd0);
    chk({tag, "_pt"},  {31'b0, pred_taken_f}, 32'd0);
    chk({tag, "_mis"}, {31'b0, misalign_o},   32'd0);
    chk({tag, "_bad"}, bad_addr_o,            32'd0);
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // T1: first edge raises fetch_valid only, then sequential 4, 8, C.
    idle(4);
    // T2: stalled calls must not touch PC or RAS; a later ret then falls through.
    go(32'h10);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 0, 0, 1);
    // T3: redirect beats stall; trap beats both.
    step(0, 1, 32'h200, 1, 0, 0);
    step(1, 1, 32'h300, 1, 0, 0);
    // T4: misaligned redirect pulses misalign_o once.
    step(0, 1, 32'h202, 0, 0, 0);
    idle(2);
    // T5: five calls overflow the 4-deep RAS, then five rets.
    for (int i = 1; i <= 5; i++) begin
      go(32'(i * 32));
      step(0, 0, '0, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, 0, 1);
    // T6: wrap, and simultaneous call+ret.
    go(32'hFFFF_FFFC);
    idle(1);
    go(32'h4C);
    step(0, 0, '0, 0, 1, 0);
    go(32'h30);
    step(0, 0, '0, 0, 1, 1);
    step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);

    // Random traffic with an asynchronous reset dropped in mid-run.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      a = {22'($urandom), 8'($urandom), 2'b00};
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8;
      if ($urandom_range(0, 3) == 0)  a[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, a,
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
